// File: rtl/hazard_unit.sv
// Load-use/branch/jump hazard and run-drain-halt sequencer feeding the ID-stage decoder.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_unit #(
  parameter int LOAD_STALL  = 1,
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             id_jump,
  input  logic             id_fin,
  input  logic             ex_branch_taken,
  output logic             ctrl_enable,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = 4;

  // state | meaning: IDLE wait start | RUN issue | STALL extra load-use bubbles | DRAIN fin retiring | HALT stopped
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic            bubble;

  assign load_use = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_enable = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    bubble      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        ctrl_enable = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          ctrl_enable = 1'b0;
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          bubble      = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = S_STALL;
            cnt_d   = CW'(LOAD_STALL - 2);
          end
        end else if (id_fin) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          state_d    = S_DRAIN;
          cnt_d      = CW'(DRAIN_DEPTH - 1);
        end else if (id_jump) begin
          ifid_flush = 1'b1;
        end
      end
      S_STALL, S_DRAIN: begin
        // A taken branch is older than the stalled/draining instruction, so it wins.
        if (ex_branch_taken) begin
          ctrl_enable = 1'b1;
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          state_d     = S_RUN;
          cnt_d       = '0;
        end else begin
          bubble = (state_q == S_STALL);
          if (cnt_q == '0) state_d = (state_q == S_STALL) ? S_RUN : S_HALT;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = bubble;
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
